// File: rtl/latch_bank_writer.sv
// -----------------------------------------------------------------------------
// latch_bank_writer
//
// Write-side driver for a bank of gated D latches (data input A, gate EN).
// A word is accepted over a valid/ready handshake and placed on o_a. The gate
// then runs through three phases: SETUP (A stable, EN low), STROBE (EN high)
// and HOLD (EN low, A still stable). In CHECK the latch outputs are compared
// with o_a and any mismatch sets a sticky error flag. CHECK ends the sequence
// and raises a one-cycle done pulse.
//
// Ports
//   i_clk      in   1      clock, rising edge
//   i_rst_n    in   1      asynchronous reset, active low
//   i_din      in   WIDTH  word to write
//   i_valid    in   1      i_din valid
//   o_ready    out  1      block can accept; a transfer happens on an edge
//                          where i_valid & o_ready
//   o_a        out  WIDTH  data to the latch bank D inputs (registered)
//   o_en       out  1      latch gate, active high (registered, glitch-free)
//   i_q        in   WIDTH  latch bank Q outputs, for readback
//   o_done     out  1      one-cycle pulse: write sequence complete
//   o_err      out  1      sticky readback mismatch flag
//   i_err_clr  in   1      synchronous clear of o_err (a new error wins)
// -----------------------------------------------------------------------------
module latch_bank_writer #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_a,
  output logic             o_en,
  input  logic [WIDTH-1:0] i_q,
  output logic             o_done,
  output logic             o_err,
  input  logic             i_err_clr
);

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  // A phase length of zero would collapse the gate timing; refuse to build.
  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_phase_len
    $error("latch_bank_writer: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_CHECK
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [WIDTH-1:0]   r_a;
  logic               r_en;
  logic               r_ready;
  logic               r_done;
  logic               r_err;
  logic               w_accept;
  logic               w_cnt_zero;
  logic               w_mismatch;

  // r_ready is only ever high while r_state is IDLE, so it alone qualifies a transfer.
  assign w_accept   = r_ready & i_valid;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_mismatch = (r_state == S_CHECK) && (i_q != r_a);

  // Next-state and phase counter
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_SETUP;
          w_cnt_next   = CNT_W'(SETUP_CYC - 1);
        end
      end
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_state_next = S_STROBE;
          w_cnt_next   = CNT_W'(PULSE_CYC - 1);
        end else begin
          w_cnt_next   = r_cnt - CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (w_cnt_zero) begin
          w_state_next = S_HOLD;
          w_cnt_next   = CNT_W'(HOLD_CYC - 1);
        end else begin
          w_cnt_next   = r_cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (w_cnt_zero) begin
          w_state_next = S_CHECK;
        end else begin
          w_cnt_next   = r_cnt - CNT_W'(1);
        end
      end
      S_CHECK: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State, data and registered outputs. EN, READY and DONE are decoded from
  // the next state so each one comes straight from a flop and lines up
  // exactly with the state it belongs to.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_en    <= 1'b0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_a <= i_din;
      end
      r_en    <= (w_state_next == S_STROBE);
      r_ready <= (w_state_next == S_IDLE);
      r_done  <= (w_state_next == S_CHECK);
      if (w_mismatch) begin
        r_err <= 1'b1;
      end else if (i_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign o_ready = r_ready;
  assign o_a     = r_a;
  assign o_en    = r_en;
  assign o_done  = r_done;
  assign o_err   = r_err;

endmodule
